// File: rtl/ble_pad_decoder.sv
// Bluefruit control-pad packet decoder: frames "!B<id><press><chk>",
// validates the checksum and hands one button event per good packet.
module ble_pad_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 7425000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid_in,
    output logic             cmd_valid_out,
    input  logic             cmd_ready_in,
    output logic [2:0]       cmd_button_out,
    output logic             cmd_pressed_out,
    output logic [7:0]       button_state_out,
    output logic [CNT_W-1:0] crc_err_count_out,
    output logic [CNT_W-1:0] drop_count_out,
    output logic             busy_out
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BANG,
        S_TYPE,
        S_ID,
        S_CHK
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       sum_q, sum_d;
    logic [2:0]       id_q, id_d;
    logic             press_q, press_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             valid_q, valid_d;
    logic [2:0]       btn_q, btn_d;
    logic             prs_q, prs_d;
    logic [7:0]       held_q, held_d;
    logic [CNT_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             good;
    logic             bad;
    logic             fire;

    // Packet framing FSM, running sum and inter-byte timeout
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        id_d    = id_q;
        press_d = press_q;
        tmo_d   = '0;
        good    = 1'b0;
        bad     = 1'b0;
        if (byte_valid_in) begin
            unique case (state_q)
                S_IDLE: begin
                    if (byte_in == 8'h21) begin
                        state_d = S_BANG;
                        sum_d   = 8'h21;
                    end
                end
                S_BANG: begin
                    if (byte_in == 8'h42) begin
                        state_d = S_TYPE;
                        sum_d   = sum_q + byte_in;
                    end else if (byte_in == 8'h21) begin
                        state_d = S_BANG;
                        sum_d   = 8'h21;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_TYPE: begin
                    if (byte_in >= 8'h31 && byte_in <= 8'h38) begin
                        state_d = S_ID;
                        id_d    = byte_in[2:0] - 3'd1;
                        sum_d   = sum_q + byte_in;
                    end else if (byte_in == 8'h21) begin
                        state_d = S_BANG;
                        sum_d   = 8'h21;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ID: begin
                    if (byte_in == 8'h30 || byte_in == 8'h31) begin
                        state_d = S_CHK;
                        press_d = byte_in[0];
                        sum_d   = sum_q + byte_in;
                    end else if (byte_in == 8'h21) begin
                        state_d = S_BANG;
                        sum_d   = 8'h21;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CHK: begin
                    state_d = S_IDLE;
                    if (byte_in == ~sum_q) good = 1'b1;
                    else                   bad  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q >= TMO_MAX) state_d = S_IDLE;
            else                  tmo_d   = tmo_q + 1'b1;
        end
    end

    // One-deep event slot, held-button map and saturating debug counters
    always_comb begin
        fire    = valid_q & cmd_ready_in;
        valid_d = valid_q & ~fire;
        btn_d   = btn_q;
        prs_d   = prs_q;
        held_d  = held_q;
        crc_d   = crc_q;
        drop_d  = drop_q;
        if (good) begin
            held_d[id_q] = press_q;
            if (!valid_q || fire) begin
                valid_d = 1'b1;
                btn_d   = id_q;
                prs_d   = press_q;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end
        if (bad && crc_q != '1) crc_d = crc_q + 1'b1;
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            id_q    <= '0;
            press_q <= 1'b0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            btn_q   <= '0;
            prs_q   <= 1'b0;
            held_q  <= '0;
            crc_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            press_q <= press_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            btn_q   <= btn_d;
            prs_q   <= prs_d;
            held_q  <= held_d;
            crc_q   <= crc_d;
            drop_q  <= drop_d;
        end
    end

    assign cmd_valid_out     = valid_q;
    assign cmd_button_out    = btn_q;
    assign cmd_pressed_out   = prs_q;
    assign button_state_out  = held_q;
    assign crc_err_count_out = crc_q;
    assign drop_count_out    = drop_q;
    assign busy_out          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ble_pad_decoder.sv
// Directed bench for ble_pad_decoder: hand-computed packets and
// expected events, counters, held map and timeout behaviour.
module tb_ble_pad_decoder;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_v;
    logic       bvalid;
    logic       cvalid;
    logic       cready;
    logic [2:0] cbtn;
    logic       cprs;
    logic [7:0] held;
    logic [7:0] crc;
    logic [7:0] drop;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ble_pad_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(8)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .byte_in(byte_v),
        .byte_valid_in(bvalid),
        .cmd_valid_out(cvalid),
        .cmd_ready_in(cready),
        .cmd_button_out(cbtn),
        .cmd_pressed_out(cprs),
        .button_state_out(held),
        .crc_err_count_out(crc),
        .drop_count_out(drop),
        .busy_out(busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_v = b;
        bvalid = 1'b1;
    endtask

    task automatic end_strobe();
        @(negedge clk);
        bvalid = 1'b0;
        byte_v = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input logic [7:0] e);
        send_byte(a);
        send_byte(b);
        send_byte(c);
        send_byte(d);
        send_byte(e);
        end_strobe();
    endtask

    task automatic drain();
        @(negedge clk);
        cready = 1'b1;
        @(negedge clk);
        cready = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        byte_v = 8'h00;
        bvalid = 1'b0;
        cready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", cvalid, 0);
        check("rst_held", held, 8'h00);
        check("rst_crc", crc, 0);
        check("rst_drop", drop, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // press button 5, exact one-cycle latency
        send_byte(8'h21);
        send_byte(8'h42);
        send_byte(8'h35);
        send_byte(8'h31);
        check("p5_busy", busy, 1);
        send_byte(8'h36);
        check("p5_early", cvalid, 0);
        end_strobe();
        check("p5_valid", cvalid, 1);
        check("p5_btn", cbtn, 4);
        check("p5_prs", cprs, 1);
        check("p5_held", held, 8'h10);
        check("p5_busy_end", busy, 0);
        repeat (10) @(negedge clk);
        check("p5_hold_v", cvalid, 1);
        check("p5_hold_b", cbtn, 4);
        check("p5_hold_p", cprs, 1);
        drain();
        check("p5_drained", cvalid, 0);

        // release button 5
        send_pkt(8'h21, 8'h42, 8'h35, 8'h30, 8'h37);
        check("r5_valid", cvalid, 1);
        check("r5_btn", cbtn, 4);
        check("r5_prs", cprs, 0);
        check("r5_held", held, 8'h00);
        drain();

        // resync on repeated '!'
        send_byte(8'h21);
        send_byte(8'h42);
        send_byte(8'h21);
        send_byte(8'h42);
        send_byte(8'h33);
        send_byte(8'h31);
        send_byte(8'h38);
        end_strobe();
        check("rs_valid", cvalid, 1);
        check("rs_btn", cbtn, 2);
        check("rs_prs", cprs, 1);
        check("rs_held", held, 8'h04);
        drain();
        check("rs_single", cvalid, 0);
        check("rs_crc0", crc, 0);

        // wrong checksum on release of button 3
        send_pkt(8'h21, 8'h42, 8'h33, 8'h30, 8'hFF);
        check("ff_valid", cvalid, 0);
        check("ff_crc", crc, 1);
        check("ff_held", held, 8'h04);

        // '!' in checksum position is a checksum, FSM back to IDLE
        send_pkt(8'h21, 8'h42, 8'h38, 8'h31, 8'h21);
        check("cp_crc", crc, 2);
        check("cp_busy", busy, 0);
        send_byte(8'h42);
        send_byte(8'h33);
        send_byte(8'h31);
        send_byte(8'h38);
        end_strobe();
        check("cp_noevt", cvalid, 0);
        check("cp_idle", busy, 0);

        // bad checksum: count then saturate
        send_pkt(8'h21, 8'h42, 8'h35, 8'h31, 8'h00);
        check("bc_crc", crc, 3);
        check("bc_valid", cvalid, 0);
        check("bc_held", held, 8'h04);
        for (int i = 0; i < 300; i++)
            send_pkt(8'h21, 8'h42, 8'h35, 8'h31, 8'h00);
        check("bc_sat", crc, 8'hFF);
        check("bc_held2", held, 8'h04);

        // clear button 3 properly
        send_pkt(8'h21, 8'h42, 8'h33, 8'h30, 8'h39);
        check("r3_held", held, 8'h00);
        drain();

        // overflow of the one-deep slot
        send_pkt(8'h21, 8'h42, 8'h31, 8'h31, 8'h3A);
        send_pkt(8'h21, 8'h42, 8'h32, 8'h31, 8'h39);
        check("ov_valid", cvalid, 1);
        check("ov_btn", cbtn, 0);
        check("ov_prs", cprs, 1);
        check("ov_drop", drop, 1);
        check("ov_held", held, 8'h03);

        // handshake in the same cycle as a good packet reloads
        send_byte(8'h21);
        send_byte(8'h42);
        send_byte(8'h31);
        send_byte(8'h30);
        send_byte(8'h3B);
        cready = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        cready = 1'b0;
        check("hs_valid", cvalid, 1);
        check("hs_btn", cbtn, 0);
        check("hs_prs", cprs, 0);
        check("hs_drop", drop, 1);
        check("hs_held", held, 8'h02);
        drain();
        check("hs_drained", cvalid, 0);

        // inter-byte timeout
        send_byte(8'h21);
        send_byte(8'h42);
        end_strobe();
        check("to_busy", busy, 1);
        repeat (TMO - 10) @(negedge clk);
        check("to_still", busy, 1);
        repeat (20) @(negedge clk);
        check("to_idle", busy, 0);
        send_byte(8'h33);
        send_byte(8'h31);
        send_byte(8'h3B);
        end_strobe();
        check("to_noevt", cvalid, 0);
        check("to_held", held, 8'h02);
        check("to_drop", drop, 1);

        // asynchronous reset mid-packet with a full slot
        send_pkt(8'h21, 8'h42, 8'h38, 8'h31, 8'h33);
        check("ar_pre_v", cvalid, 1);
        check("ar_pre_h", held, 8'h82);
        send_byte(8'h21);
        send_byte(8'h42);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", cvalid, 0);
        check("ar_btn", cbtn, 0);
        check("ar_prs", cprs, 0);
        check("ar_held", held, 8'h00);
        check("ar_crc", crc, 0);
        check("ar_drop", drop, 0);
        check("ar_busy", busy, 0);
        bvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h35);
        send_byte(8'h31);
        send_byte(8'h36);
        end_strobe();
        check("ar_after", cvalid, 0);
        check("ar_after_b", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ble_pad_decoder.md
Name: ble_pad_decoder

Overview:
- Sits between `uart_rx` (byte stream from the BLE module) and `gameplay`.
- Frames Bluefruit control-pad packets: `'!' 'B' <id '1'..'8'> <'1' press / '0' release> <checksum>`.
- Validates each packet and emits one button event per good packet over a valid/ready handshake.
- Also keeps a live 8-bit held-button map, plus error and drop counters for seven-seg debug.

Parameters:
- TIMEOUT_CYCLES, 7425000: max clk_in cycles between bytes of one packet before resync (100 ms at 74.25 MHz).
- CNT_W, 8: width of the saturating error/drop counters.

Ports:
- clk_in  input  1  pixel clock, 74.25 MHz.
- rst_n_in  input  1  asynchronous, active-low reset.
- byte_in  input  8  received byte from uart_rx.
- byte_valid_in  input  1  one-cycle strobe; byte_in valid this cycle.
- cmd_valid_out  output  1  event held and available.
- cmd_ready_in  input  1  consumer accepts event when high with cmd_valid_out.
- cmd_button_out  output  3  button index, 0..7 (ASCII id minus '1').
- cmd_pressed_out  output  1  1 = press, 0 = release.
- button_state_out  output  8  bit i = button i currently held.
- crc_err_count_out  output  CNT_W  saturating count of checksum failures.
- drop_count_out  output  CNT_W  saturating count of good packets lost to a full output slot.
- busy_out  output  1  high whenever FSM is not in IDLE.

Behaviour:
- Reset (rst_n_in low, async) takes effect immediately; every output and internal register goes to 0; FSM goes to IDLE.
- Reset asserted mid-packet discards the partial packet; no event, no counter change.
- FSM advances only on cycles with byte_valid_in=1.
- IDLE:
  - 0x21 ('!') -> BANG; sum <= 0x21.
  - Any other byte is ignored.
- BANG:
  - 0x42 ('B') -> TYPE; sum += byte.
  - 0x21 -> stay in BANG; sum <= 0x21.
  - Any other byte -> IDLE.
- TYPE:
  - 0x31..0x38 -> ID; latch id = byte-0x31; sum += byte.
  - 0x21 -> BANG.
  - Any other byte -> IDLE.
- ID:
  - 0x30 or 0x31 -> CHK; latch press = byte[0]; sum += byte.
  - 0x21 -> BANG.
  - Any other byte -> IDLE.
- CHK:
  - Any byte value, including 0x21, is treated as the checksum; FSM -> IDLE.
  - Pass if byte == ~sum[7:0] (8-bit sum, carries discarded).
  - Fail: crc_err_count_out += 1, saturating at all-ones; no other effect.
- Timeout:
  - A counter clears on every byte_valid_in and increments each cycle while not in IDLE.
  - On reaching TIMEOUT_CYCLES, FSM -> IDLE the next cycle, with no event and no counter change.
- Good packet, next cycle after the checksum byte:
  - button_state_out[id] <= press, always, regardless of output slot.
  - If slot empty, or a handshake completes this same cycle: load cmd_button_out/cmd_pressed_out, cmd_valid_out <= 1.
  - Otherwise: drop_count_out += 1 (saturating); the held event is unchanged.
- Output slot is one-deep:
  - cmd_valid_out stays high with stable fields until the cycle with cmd_ready_in=1.
  - It deasserts the following cycle unless reloaded as above.
  - cmd_ready_in with cmd_valid_out=0 has no effect.
- Latency: checksum-byte strobe to cmd_valid_out high is 1 cycle.
- Back-to-back strobes on consecutive cycles must be handled; each strobe is one byte.

Test Plan:
- Press button 5: bytes 21 42 35 31 36 -> cmd_valid_out=1 one cycle after 0x36, cmd_button_out=4, cmd_pressed_out=1, button_state_out=0x10; hold cmd_ready_in=0 for 10 cycles -> fields stable; pulse ready -> cmd_valid_out=0 next cycle.
- Release button 5: bytes 21 42 35 30 37 -> event button 4, pressed 0; button_state_out=0x00.
- Bad checksum: 21 42 35 31 00 -> no event, crc_err_count_out=1, button_state_out unchanged; repeat 300 times -> saturates at 0xFF.
- Resync: 21 42 21 42 33 31 38 -> single event, button 2, pressed 1; then 21 42 33 30 FF (0xFF: wrong checksum; correct is 0x39) -> crc error. Checksum position: 21 42 38 31 21 -> 0x21 taken as a (failing) checksum, FSM returns to IDLE, not BANG.
- Overflow: cmd_ready_in=0; send press 1 (21 42 31 31 3A) then press 2 (21 42 32 31 39) -> slot holds button 0, drop_count_out=1, button_state_out=0x03.
- Timeout and reset: send 21 42 then idle TIMEOUT_CYCLES (override parameter to 100 in bench) -> busy_out=0, and a trailing 33 31 3B produces no event. Separately, assert rst_n_in mid-packet -> all outputs 0 immediately, asynchronously to clk_in.
